// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC sequencer.
// Latency: n/a. Backpressure: n/a.
package pc_seq_pkg;

    localparam int unsigned PC_WIDTH_DEF = 5;
    // Wide enough for the largest legal FETCH_CYCLES (8 -> counts 0..7).
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_UPDATE = 2'd2,
        ST_HALTED = 2'd3
    } state_e;

endpackage

// File: rtl/pc_seq_cycle_counter.sv
// FETCH-phase cycle counter with synchronous clear and terminal-count flag.
// Latency: count updates one cycle after enable; tc_o is combinational from the count.
// Backpressure: holds while en_i is low; clr_i has priority over en_i.
module pc_seq_cycle_counter
    import pc_seq_pkg::*;
#(
    parameter int unsigned TERMINAL = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE -> FETCH (FETCH_CYCLES) -> UPDATE loop, HALTED until reset.
// Latency: PCWrite/PCNext are registered and appear the cycle after a non-stalled UPDATE.
// Backpressure: Stall freezes FETCH counting and holds UPDATE; optional branches via PC_SEQ_BRANCH_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned FETCH_CYCLES = 2,
    parameter int unsigned PC_WIDTH     = PC_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                stall_i,
    input  logic                halt_i,
    input  logic                branch_req_i,
    input  logic [PC_WIDTH-1:0] branch_target_i,
    input  logic [PC_WIDTH-1:0] pc_result_i,
    output logic [PC_WIDTH-1:0] pc_next_o,
    output logic                pc_write_o,
    output logic                fetch_valid_o,
    output logic                busy_o,
    output logic                halted_o
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_next_q, pc_next_d;
    logic                pc_write_q, pc_write_d;
    logic                halt_q, halt_d;
    logic                cnt_clr, cnt_en, cnt_tc;
    logic                do_update;
    logic [PC_WIDTH-1:0] pc_inc, upd_pc;

    assign do_update = (state_q == ST_UPDATE) && !stall_i;
    assign pc_inc    = pc_result_i + PC_WIDTH'(1);

`ifdef PC_SEQ_BRANCH_EN
    logic                pend_q, pend_d;
    logic [PC_WIDTH-1:0] tgt_q, tgt_d;

    always_comb begin
        pend_d = pend_q;
        tgt_d  = tgt_q;
        if (branch_req_i) begin
            pend_d = 1'b1;
            tgt_d  = branch_target_i;
        end
        if (do_update) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 1'b0;
            tgt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            tgt_q  <= tgt_d;
        end
    end

    // A request arriving in the updating cycle itself is newer than any pending one.
    assign upd_pc = branch_req_i ? branch_target_i : (pend_q ? tgt_q : pc_inc);
`else
    logic unused_branch;
    assign unused_branch = ^{branch_req_i, branch_target_i};
    assign upd_pc        = pc_inc;
`endif

    pc_seq_cycle_counter #(
        .TERMINAL (FETCH_CYCLES)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (cnt_clr),
        .en_i  (cnt_en),
        .tc_o  (cnt_tc)
    );

    always_comb begin
        state_d    = state_q;
        pc_next_d  = pc_next_q;
        pc_write_d = 1'b0;
        halt_d     = halt_q | halt_i;
        cnt_clr    = (state_q != ST_FETCH);
        cnt_en     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!stall_i) begin
                    if (cnt_tc) begin
                        state_d = ST_UPDATE;
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_UPDATE: begin
                if (do_update) begin
                    pc_write_d = 1'b1;
                    pc_next_d  = upd_pc;
                    halt_d     = 1'b0;
                    state_d    = (halt_i || halt_q) ? ST_HALTED : ST_FETCH;
                end
            end
            default: begin
                state_d = ST_HALTED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_next_q  <= '0;
            pc_write_q <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_next_q  <= pc_next_d;
            pc_write_q <= pc_write_d;
            halt_q     <= halt_d;
        end
    end

    assign pc_next_o     = pc_next_q;
    assign pc_write_o    = pc_write_q;
    assign fetch_valid_o = (state_q == ST_FETCH) && cnt_tc;
    assign busy_o        = (state_q == ST_FETCH) || (state_q == ST_UPDATE);
    assign halted_o      = (state_q == ST_HALTED);

endmodule
